// File: rtl/intpol2_run_ctrl.sv
// Run controller for the IQ quadratic interpolator: config words, output-length calc,
// start/source sequencing and output FIFO drain. Optional macro: INTPOL2_DRAIN_WDT_EN.
module intpol2_run_ctrl #(
  parameter int unsigned CONFIG_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned WDT_CYCLES   = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_addr,
  input  logic [CONFIG_WIDTH-1:0]   cfg_wdata,
  input  logic [ADDR_WIDTH-1:0]     sig_len_i,
  input  logic                      go_i,
  input  logic                      abort_i,
  input  logic                      core_done_i,
  input  logic                      Empty_i,
  output logic [4*CONFIG_WIDTH-1:0] config_reg_o,
  output logic                      start_o,
  output logic                      src_en_o,
  output logic                      Read_Enable_o,
  output logic                      Write_Enable_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [ADDR_WIDTH-1:0]     total_len_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int unsigned PW    = 2 * ADDR_WIDTH;
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
`ifdef INTPOL2_DRAIN_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_RUN, S_DRAIN, S_DONE, S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [CONFIG_WIDTH-1:0] cfg_q [4];
  logic [ADDR_WIDTH-1:0]   sig_len_q, sig_len_d;
  logic [ADDR_WIDTH-1:0]   total_q, total_d;
  logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WDT_W-1:0]        wdt_q, wdt_d;
  logic                    we_q, we_d;
  logic                    start_q, src_en_q, busy_q, done_q, err_q;
  logic                    cfg_take_c, rd_en_c, param_err_c;
  logic [ADDR_WIDTH-1:0]   ilen_c;
  logic [PW-1:0]           total_full_c;

  assign ilen_c       = cfg_q[3][ADDR_WIDTH-1:0];
  assign total_full_c = (PW'(sig_len_q) * PW'(ilen_c)) - (PW'(ilen_c) << 1);
  assign param_err_c  = (ilen_c == '0) || (sig_len_q < ADDR_WIDTH'(3)) ||
                        (total_full_c[PW-1:ADDR_WIDTH] != '0);
  assign cfg_take_c   = cfg_we && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  // FIFO read must react to Empty_i in the same cycle, so it is a direct decode
  assign rd_en_c      = (state_q == S_RUN || state_q == S_DRAIN) && !Empty_i &&
                        (rd_cnt_q < total_q);

  always_comb begin
    state_d   = state_q;
    sig_len_d = sig_len_q;
    total_d   = total_q;
    rd_cnt_d  = rd_cnt_q + ADDR_WIDTH'(rd_en_c);
    addr_d    = addr_q + ADDR_WIDTH'(we_q);
    we_d      = rd_en_c;
    wdt_d     = (WDT_EN && state_q == S_DRAIN && Empty_i && !rd_en_c) ? wdt_q + WDT_W'(1) : '0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (go_i) begin
          state_d   = S_CHECK;
          sig_len_d = sig_len_i;
          rd_cnt_d  = '0;
          addr_d    = '0;
          we_d      = 1'b0;
        end
      end
      S_CHECK: begin
        if (param_err_c) begin
          state_d = S_ERR;
        end else begin
          total_d = total_full_c[ADDR_WIDTH-1:0];
          state_d = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (addr_d == total_q)  state_d = S_DONE;
        else if (core_done_i)   state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (addr_d == total_q)                              state_d = S_DONE;
        else if (WDT_EN && wdt_d == WDT_W'(WDT_CYCLES))     state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything, including a simultaneous go and an in-flight write
    if (abort_i) begin
      state_d  = S_IDLE;
      rd_cnt_d = '0;
      addr_d   = '0;
      we_d     = 1'b0;
      wdt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < 4; i++) cfg_q[i] <= '0;
      sig_len_q <= '0;
      total_q   <= '0;
      rd_cnt_q  <= '0;
      addr_q    <= '0;
      wdt_q     <= '0;
      we_q      <= 1'b0;
      start_q   <= 1'b0;
      src_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (cfg_take_c) cfg_q[cfg_addr] <= cfg_wdata;
      sig_len_q <= sig_len_d;
      total_q   <= total_d;
      rd_cnt_q  <= rd_cnt_d;
      addr_q    <= addr_d;
      wdt_q     <= wdt_d;
      we_q      <= we_d;
      start_q   <= (state_d == S_START);
      src_en_q  <= (state_d == S_RUN);
      busy_q    <= (state_d == S_CHECK) || (state_d == S_START) ||
                   (state_d == S_RUN)   || (state_d == S_DRAIN);
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_d == S_ERR);
    end
  end

  assign config_reg_o   = {cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};
  assign start_o        = start_q;
  assign src_en_o       = src_en_q;
  assign Read_Enable_o  = rd_en_c;
  assign Write_Enable_o = we_q;
  assign addr_o         = addr_q;
  assign total_len_o    = total_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_intpol2_run_ctrl.sv
// Randomized self-checking bench for intpol2_run_ctrl with an arithmetic length model
// and a read/write scoreboard.
module tb_intpol2_run_ctrl;

  localparam int unsigned CW  = 32;
  localparam int unsigned AW  = 20;
  localparam int unsigned WDT = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_addr = '0;
  logic [CW-1:0]   cfg_wdata = '0;
  logic [AW-1:0]   sig_len_i = '0;
  logic            go_i = 1'b0, abort_i = 1'b0, core_done_i = 1'b0, Empty_i = 1'b1;
  logic [4*CW-1:0] config_reg_o;
  logic            start_o, src_en_o, Read_Enable_o, Write_Enable_o;
  logic [AW-1:0]   addr_o, total_len_o;
  logic            busy_o, done_o, err_o;

  intpol2_run_ctrl #(.CONFIG_WIDTH(CW), .ADDR_WIDTH(AW), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .sig_len_i(sig_len_i), .go_i(go_i), .abort_i(abort_i), .core_done_i(core_done_i),
    .Empty_i(Empty_i), .config_reg_o(config_reg_o), .start_o(start_o), .src_en_o(src_en_o),
    .Read_Enable_o(Read_Enable_o), .Write_Enable_o(Write_Enable_o), .addr_o(addr_o),
    .total_len_o(total_len_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard state, sampled on the falling edge
  int rd_seen = 0, wr_seen = 0, st_seen = 0;
  longint exp_total = 0;
  bit prev_rd = 0, prev_abort = 0, prev_we = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_rd = 0; prev_abort = 0; prev_we = 0;
    end else begin
      check_eq("we_follows_rd", 64'(Write_Enable_o), 64'(prev_rd && !prev_abort));
      if (Write_Enable_o) begin
        check_eq("wr_addr", 64'(addr_o), 64'(wr_seen));
        wr_seen++;
      end
      if (Read_Enable_o) begin
        check_eq("rd_on_empty", 64'(Empty_i), 64'd0);
        check_eq("rd_bound", 64'(longint'(rd_seen) < exp_total), 64'd1);
        rd_seen++;
      end
      if (start_o) st_seen++;
      prev_rd = Read_Enable_o; prev_abort = abort_i; prev_we = Write_Enable_o;
    end
  end

  // expected output length straight from the length formula
  function automatic bit model_err(input longint unsigned sl, input longint unsigned il,
                                   output longint unsigned tot);
    tot = 0;
    if (il == 0 || sl < 3) return 1'b1;
    tot = sl * il - 2 * il;
    return tot >= (longint'(1) << AW);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [CW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input longint unsigned sl, input longint unsigned tot);
    exp_total = longint'(tot); rd_seen = 0; wr_seen = 0; st_seen = 0;
    Empty_i = 1'b1; core_done_i = 1'b0;
    sig_len_i = AW'(sl); go_i = 1'b1;
    step();
    go_i = 1'b0;
  endtask

  task automatic run_case(input string tag, input int unsigned sl, input int unsigned il,
                          input int unsigned empty_pct, input int cd_at);
    logic [CW-1:0] w3;
    longint unsigned tot;
    bit is_err;
    bit finished;
    w3 = ($urandom & 32'hFFF0_0000) | CW'(il);
    cfg_write(2'd3, w3);
    check_eq({tag, "_cfg_w3"}, 64'(config_reg_o[4*CW-1:3*CW]), 64'(w3));
    is_err = model_err(sl, il, tot);
    start_run(sl, is_err ? 0 : tot);
    check_eq({tag, "_check_busy"}, 64'({busy_o, start_o, done_o, err_o}), 64'b1000);
    step();
    if (is_err) begin
      check_eq({tag, "_err"}, 64'({err_o, busy_o, start_o}), 64'b100);
      repeat (3) step();
      check_eq({tag, "_no_start"}, 64'(st_seen), 64'd0);
      check_eq({tag, "_err_held"}, 64'(err_o), 64'd1);
      return;
    end
    check_eq({tag, "_start"}, 64'({start_o, src_en_o}), 64'b10);
    check_eq({tag, "_total"}, 64'(total_len_o), 64'(tot));
    step();
    check_eq({tag, "_src_en"}, 64'({start_o, src_en_o}), 64'b01);
    finished = 0;
    for (int c = 0; c < 5000 && !finished; c++) begin
      Empty_i = ($urandom_range(99) < empty_pct);
      core_done_i = (wr_seen >= cd_at);
      step();
      if (done_o) finished = 1;
    end
    check_eq({tag, "_done"}, 64'(done_o), 64'd1);
    check_eq({tag, "_done_after_last_wr"}, 64'(prev_we), 64'd1);
    check_eq({tag, "_wr_count"}, 64'(wr_seen), 64'(tot));
    check_eq({tag, "_done_status"}, 64'({busy_o, src_en_o, err_o}), 64'b000);
    Empty_i = 1'b0; core_done_i = 1'b0;
    repeat (5) step();
    check_eq({tag, "_done_held"}, 64'(done_o), 64'd1);
    check_eq({tag, "_no_extra_wr"}, 64'(wr_seen), 64'(tot));
  endtask

  initial begin
    int w;
    bit hit;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", 64'({start_o, src_en_o, Read_Enable_o, Write_Enable_o,
                                  busy_o, done_o, err_o}), 64'd0);
    check_eq("rst_addr_total", 64'({addr_o, total_len_o}), 64'd0);
    check_eq("rst_cfg", 64'(config_reg_o != '0), 64'd0);
    rstn = 1'b1;
    step();

    cfg_write(2'd0, 32'h1234_5678);
    check_eq("cfg_w0_idle", 64'(config_reg_o[CW-1:0]), 64'h1234_5678);

    run_case("normal", 10, 26, 0, 1 << 30);
    run_case("ilen0", 10, 0, 0, 1 << 30);
    run_case("short", 2, 26, 0, 1 << 30);
    run_case("ovf", 1 << 19, 4, 0, 1 << 30);
    run_case("gaps", 10, 26, 40, 150);
    for (int i = 0; i < 8; i++)
      run_case($sformatf("rnd%0d", i), $urandom_range(40), $urandom_range(9),
               $urandom_range(60), int'($urandom_range(300)));

    // abort with a simultaneous go during RUN; config write in RUN must be ignored
    cfg_write(2'd3, 32'd26);
    start_run(10, 208);
    step(); step();
    Empty_i = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'hDEAD_BEEF;
    step();
    cfg_we = 1'b0;
    check_eq("cfg_ignored_run", 64'(config_reg_o[CW-1:0]), 64'h1234_5678);
    for (int c = 0; c < 400 && wr_seen < 50; c++) step();
    check_eq("abort_reached_50", 64'(wr_seen >= 50), 64'd1);
    abort_i = 1'b1; go_i = 1'b1;
    step();
    abort_i = 1'b0; go_i = 1'b0;
    check_eq("abort_idle", 64'({busy_o, src_en_o, start_o, Write_Enable_o, Read_Enable_o,
                                done_o, err_o}), 64'd0);
    check_eq("abort_addr", 64'(addr_o), 64'd0);
    w = wr_seen;
    repeat (5) step();
    check_eq("abort_no_wr", 64'(wr_seen), 64'(w));
    check_eq("abort_stay_idle", 64'(busy_o), 64'd0);
    cfg_write(2'd0, 32'hDEAD_BEEF);
    check_eq("cfg_taken_idle", 64'(config_reg_o[CW-1:0]), 64'hDEAD_BEEF);

    // drain with the FIFO held empty
    start_run(10, 208);
    step(); step();
    Empty_i = 1'b0;
    for (int c = 0; c < 400 && wr_seen < 100; c++) step();
    core_done_i = 1'b1; Empty_i = 1'b1;
`ifdef INTPOL2_DRAIN_WDT_EN
    hit = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k < 17) check_eq($sformatf("wdt_not_yet_%0d", k), 64'(err_o), 64'd0);
      else        hit = err_o;
    end
    check_eq("wdt_err_at_16", 64'(hit), 64'd1);
    core_done_i = 1'b0;
`else
    hit = 0;
    repeat (1000) step();
    check_eq("drain_wait", 64'({busy_o, src_en_o, done_o, err_o}), 64'b1000);
    core_done_i = 1'b0;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_eq("drain_abort", 64'(busy_o), 64'd0);
`endif

    // asynchronous reset in the middle of a run
    cfg_write(2'd3, 32'd26);
    start_run(10, 208);
    step(); step();
    Empty_i = 1'b0;
    repeat (20) step();
    #2 rstn = 1'b0;
    #1;
    check_eq("async_rst", 64'({start_o, src_en_o, Read_Enable_o, Write_Enable_o,
                                busy_o, done_o, err_o}), 64'd0);
    check_eq("async_rst_cfg", 64'(config_reg_o != '0), 64'd0);
    check_eq("async_rst_addr", 64'({addr_o, total_len_o}), 64'd0);
    step();
    rstn = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
